// File: rtl/ack_state_tracker_pkg.sv
// Shared TCP slow-path types for the multi-flow ACK state tracker:
// table entry and update bundle layouts plus default sizing constants.
package ack_state_tracker_pkg;

   localparam int RT_ACK_THRESHOLD = 3;
   localparam int ATS_NUM_FLOWS    = 16;
   localparam int ATS_FLOW_ID_W    = $clog2(ATS_NUM_FLOWS);
   localparam int ATS_SEQ_W        = 32;
   localparam int ATS_DUP_CNT_W    = $clog2(RT_ACK_THRESHOLD + 1);
   localparam int ATS_TX_PTR_W     = 16;

   typedef struct packed {
      logic [ATS_SEQ_W-1:0]     ack_num;
      logic [ATS_DUP_CNT_W-1:0] dup_cnt;
   } ack_tbl_entry_struct;

   typedef struct packed {
      logic [ATS_FLOW_ID_W-1:0] flow_id;
      logic [ATS_SEQ_W-1:0]     ack_num;
      logic                     advanced;
      logic                     rt;
   } ack_upd_struct;

endpackage

// File: rtl/ack_state_tracker_if.sv
// Init / received-ACK request channels and the update channel towards TX logic.
// The master drives requests and consumes updates; the tracker is the slave.
interface ack_state_tracker_if
   import ack_state_tracker_pkg::*;
#(
   parameter int FLOW_ID_W = ATS_FLOW_ID_W,
   parameter int SEQ_W     = ATS_SEQ_W,
   parameter int TX_PTR_W  = ATS_TX_PTR_W
);
   logic                 init_val;
   logic                 init_rdy;
   logic [FLOW_ID_W-1:0] init_flow_id;
   logic [SEQ_W-1:0]     init_ack_num;
   logic                 ack_val;
   logic                 ack_rdy;
   logic [FLOW_ID_W-1:0] ack_flow_id;
   logic [SEQ_W-1:0]     ack_num;
   logic [SEQ_W-1:0]     ack_snd_nxt;
   logic                 upd_val;
   logic                 upd_rdy;
   logic [FLOW_ID_W-1:0] upd_flow_id;
   logic [SEQ_W-1:0]     upd_ack_num;
   logic [TX_PTR_W-1:0]  upd_tx_head_ptr;
   logic                 upd_advanced;
   logic                 upd_rt;

   modport master (
      output init_val, init_flow_id, init_ack_num,
      output ack_val, ack_flow_id, ack_num, ack_snd_nxt,
      output upd_rdy,
      input  init_rdy, ack_rdy,
      input  upd_val, upd_flow_id, upd_ack_num, upd_tx_head_ptr, upd_advanced, upd_rt
   );

   modport slave (
      input  init_val, init_flow_id, init_ack_num,
      input  ack_val, ack_flow_id, ack_num, ack_snd_nxt,
      input  upd_rdy,
      output init_rdy, ack_rdy,
      output upd_val, upd_flow_id, upd_ack_num, upd_tx_head_ptr, upd_advanced, upd_rt
   );

endinterface

// File: rtl/ack_state_calc.sv
// Pure S1 update function: validates one ACK against a flow's stored state and
// returns the next table entry plus the advance / fast-retransmit flags.
module ack_state_calc
   import ack_state_tracker_pkg::*;
#(
   parameter int SEQ_W      = ATS_SEQ_W,
   parameter int DUP_THRESH = RT_ACK_THRESHOLD,
   parameter int DUP_CNT_W  = $clog2(DUP_THRESH + 1)
) (
   input  ack_tbl_entry_struct i_cur,
   input  logic [SEQ_W-1:0]    i_ack_num,
   input  logic [SEQ_W-1:0]    i_snd_nxt,
   output ack_tbl_entry_struct o_next,
   output logic                o_advance,
   output logic                o_rt
);
   logic [SEQ_W-1:0]     w_d_ack;
   logic [SEQ_W-1:0]     w_d_out;
   logic                 w_unacked;
   logic                 w_dup;
   logic [DUP_CNT_W-1:0] w_cnt_inc;

   // Offsets from the stored ACK are taken mod 2^SEQ_W so the window test survives wrap.
   always_comb begin
      w_d_ack   = i_ack_num - i_cur.ack_num;
      w_d_out   = i_snd_nxt - i_cur.ack_num;
      w_unacked = (w_d_out != {SEQ_W{1'b0}});
      o_advance = w_unacked & (w_d_ack != {SEQ_W{1'b0}}) & (w_d_ack <= w_d_out);
      w_dup     = w_unacked & (w_d_ack == {SEQ_W{1'b0}});
      w_cnt_inc = i_cur.dup_cnt + DUP_CNT_W'(1);
      o_rt      = w_dup & (w_cnt_inc == DUP_CNT_W'(DUP_THRESH));
      if (o_advance) begin
         o_next.ack_num = i_ack_num;
      end else begin
         o_next.ack_num = i_cur.ack_num;
      end
      if (w_dup && !o_rt) begin
         o_next.dup_cnt = w_cnt_inc;
      end else begin
         o_next.dup_cnt = {DUP_CNT_W{1'b0}};
      end
   end

endmodule

// File: rtl/ack_state_tracker.sv
// Multi-flow ACK state table with a 2-stage read-modify-write pipeline,
// same-flow bypass from S1, init priority and backpressured update output.
module ack_state_tracker
   import ack_state_tracker_pkg::*;
#(
   parameter int NUM_FLOWS  = ATS_NUM_FLOWS,
   parameter int FLOW_ID_W  = $clog2(NUM_FLOWS),
   parameter int SEQ_W      = ATS_SEQ_W,
   parameter int DUP_THRESH = RT_ACK_THRESHOLD,
   parameter int DUP_CNT_W  = $clog2(DUP_THRESH + 1),
   parameter int TX_PTR_W   = ATS_TX_PTR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   ack_state_tracker_if.slave bus
);
   ack_tbl_entry_struct  r_tbl [NUM_FLOWS];
   logic                 r_s1_val;
   logic [FLOW_ID_W-1:0] r_s1_flow;
   ack_tbl_entry_struct  r_s1_cur;
   logic [SEQ_W-1:0]     r_s1_ack_num;
   logic [SEQ_W-1:0]     r_s1_snd_nxt;
   logic                 r_upd_val;
   ack_upd_struct        r_upd;

   logic                 w_stall;
   logic                 w_init_acc;
   logic                 w_ack_acc;
   logic                 w_s1_adv;
   logic                 w_s1_poison;
   logic                 w_bypass;
   ack_tbl_entry_struct  w_rd_entry;
   ack_tbl_entry_struct  w_s1_next;
   logic                 w_s1_advance;
   logic                 w_s1_rt;

   ack_state_calc #(
      .SEQ_W      (SEQ_W),
      .DUP_THRESH (DUP_THRESH),
      .DUP_CNT_W  (DUP_CNT_W)
   ) u_calc (
      .i_cur     (r_s1_cur),
      .i_ack_num (r_s1_ack_num),
      .i_snd_nxt (r_s1_snd_nxt),
      .o_next    (w_s1_next),
      .o_advance (w_s1_advance),
      .o_rt      (w_s1_rt)
   );

   // Handshake decode and table read; an init aimed at S1's flow overrides S1's
   // writeback, so S1's result is poisoned and must not be forwarded.
   always_comb begin
      w_stall     = r_upd_val & ~bus.upd_rdy;
      w_init_acc  = bus.init_val & ~w_stall;
      w_ack_acc   = bus.ack_val & ~bus.init_val & ~w_stall;
      w_s1_adv    = r_s1_val & ~w_stall;
      w_s1_poison = bus.init_val & (r_s1_flow == bus.init_flow_id);
      w_bypass    = r_s1_val & ~w_s1_poison & (r_s1_flow == bus.ack_flow_id);
      if (w_bypass) begin
         w_rd_entry = w_s1_next;
      end else begin
         w_rd_entry = r_tbl[bus.ack_flow_id];
      end
   end

   // Table writes: S1 writeback first so a same-edge init to the same flow wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_FLOWS; i++) begin
            r_tbl[i] <= '{ack_num: {SEQ_W{1'b0}}, dup_cnt: {DUP_CNT_W{1'b0}}};
         end
      end else begin
         if (w_s1_adv) begin
            r_tbl[r_s1_flow] <= w_s1_next;
         end
         if (w_init_acc) begin
            r_tbl[bus.init_flow_id] <= '{ack_num: bus.init_ack_num, dup_cnt: {DUP_CNT_W{1'b0}}};
         end
      end
   end

   // S1 register: captures the accepted request and its current table state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_val     <= 1'b0;
         r_s1_flow    <= {FLOW_ID_W{1'b0}};
         r_s1_cur     <= '{ack_num: {SEQ_W{1'b0}}, dup_cnt: {DUP_CNT_W{1'b0}}};
         r_s1_ack_num <= {SEQ_W{1'b0}};
         r_s1_snd_nxt <= {SEQ_W{1'b0}};
      end else if (!w_stall) begin
         r_s1_val <= w_ack_acc;
         if (w_ack_acc) begin
            r_s1_flow    <= bus.ack_flow_id;
            r_s1_cur     <= w_rd_entry;
            r_s1_ack_num <= bus.ack_num;
            r_s1_snd_nxt <= bus.ack_snd_nxt;
         end
      end
   end

   // Output register: holds steady while the consumer applies backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_upd_val <= 1'b0;
         r_upd     <= '{flow_id: {FLOW_ID_W{1'b0}}, ack_num: {SEQ_W{1'b0}}, advanced: 1'b0, rt: 1'b0};
      end else if (!w_stall) begin
         r_upd_val <= r_s1_val;
         if (r_s1_val) begin
            r_upd <= '{flow_id: r_s1_flow, ack_num: w_s1_next.ack_num,
                       advanced: w_s1_advance, rt: w_s1_rt};
         end
      end
   end

   assign bus.init_rdy        = ~w_stall;
   assign bus.ack_rdy         = ~w_stall & ~bus.init_val;
   assign bus.upd_val         = r_upd_val;
   assign bus.upd_flow_id     = r_upd.flow_id;
   assign bus.upd_ack_num     = r_upd.ack_num;
   assign bus.upd_tx_head_ptr = r_upd.ack_num[TX_PTR_W-1:0];
   assign bus.upd_advanced    = r_upd.advanced;
   assign bus.upd_rt          = r_upd.rt;

endmodule

// File: tb/tb_ack_state_tracker.sv
// Self-checking bench for ack_state_tracker: directed scenarios plus random
// traffic, scored against a per-flow sequential model of the ACK rules.
module tb_ack_state_tracker;

   typedef struct {
      logic [3:0]  f;
      logic [31:0] a;
      logic        adv;
      logic        rt;
   } upd_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   logic [31:0] m_ack [16];
   int          m_cnt [16];
   upd_t        exp_q [$];
   upd_t        obs_q [$];
   upd_t        sb_e;
   logic        prev_stall;
   logic [63:0] held;

   ack_state_tracker_if bus ();

   ack_state_tracker dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) begin
         m_ack[i] = 32'd0;
         m_cnt[i] = 0;
      end
   endtask

   // ACK is "new" if it lies in (cur, snd_nxt] on the sequence circle.
   task automatic model_ack(input logic [3:0] f, input logic [31:0] a, input logic [31:0] s);
      logic [31:0] cur;
      logic [31:0] d_ack;
      logic [31:0] d_out;
      logic        adv;
      logic        dup;
      logic        rt;
      cur   = m_ack[f];
      d_ack = a - cur;
      d_out = s - cur;
      adv   = (s != cur) && (a != cur) && (d_ack <= d_out);
      dup   = (s != cur) && (a == cur);
      rt    = dup && (m_cnt[f] + 1 == 3);
      if (adv) m_ack[f] = a;
      m_cnt[f] = (dup && !rt) ? m_cnt[f] + 1 : 0;
      exp_q.push_back('{f, m_ack[f], adv, rt});
   endtask

   // Monitor: scoreboard, stall stability, init priority and model updates.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("upd_stable", {9'd0, bus.upd_val, bus.upd_flow_id, bus.upd_ack_num,
                 bus.upd_tx_head_ptr, bus.upd_advanced, bus.upd_rt}, held);
         end
         if (bus.upd_val && bus.upd_rdy) begin
            obs_q.push_back('{bus.upd_flow_id, bus.upd_ack_num, bus.upd_advanced, bus.upd_rt});
            chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               sb_e = exp_q.pop_front();
               chk("sb_flow", 64'(bus.upd_flow_id), 64'(sb_e.f));
               chk("sb_ack", 64'(bus.upd_ack_num), 64'(sb_e.a));
               chk("sb_ptr", 64'(bus.upd_tx_head_ptr), 64'(sb_e.a[15:0]));
               chk("sb_adv", 64'(bus.upd_advanced), 64'(sb_e.adv));
               chk("sb_rt", 64'(bus.upd_rt), 64'(sb_e.rt));
            end
         end
         if (bus.init_val) chk("ack_rdy_vs_init", 64'(bus.ack_rdy), 64'd0);
         if (bus.init_val && bus.init_rdy) begin
            m_ack[bus.init_flow_id] = bus.init_ack_num;
            m_cnt[bus.init_flow_id] = 0;
         end else if (bus.ack_val && bus.ack_rdy) begin
            model_ack(bus.ack_flow_id, bus.ack_num, bus.ack_snd_nxt);
         end
         prev_stall = bus.upd_val && !bus.upd_rdy;
         held = {9'd0, bus.upd_val, bus.upd_flow_id, bus.upd_ack_num,
                 bus.upd_tx_head_ptr, bus.upd_advanced, bus.upd_rt};
      end
   end

   task automatic send_ack(input logic [3:0] f, input logic [31:0] a, input logic [31:0] s);
      int n = 0;
      bus.ack_val = 1'b1; bus.ack_flow_id = f; bus.ack_num = a; bus.ack_snd_nxt = s;
      @(negedge clk);
      while (!bus.ack_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ack_accept", 64'(n < 50), 64'd1);
      @(posedge clk); #1;
      bus.ack_val = 1'b0;
   endtask

   task automatic send_init(input logic [3:0] f, input logic [31:0] a);
      int n = 0;
      bus.init_val = 1'b1; bus.init_flow_id = f; bus.init_ack_num = a;
      @(negedge clk);
      while (!bus.init_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("init_accept", 64'(n < 50), 64'd1);
      @(posedge clk); #1;
      bus.init_val = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      bus.upd_rdy = 1'b1;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      chk("drain", 64'(n < 40), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic expect_obs(input string tag, input logic [3:0] f, input logic [31:0] a,
                             input logic adv, input logic rt);
      upd_t o;
      chk({tag, "_present"}, 64'(obs_q.size() != 0), 64'd1);
      if (obs_q.size() != 0) begin
         o = obs_q.pop_front();
         chk({tag, "_flow"}, 64'(o.f), 64'(f));
         chk({tag, "_ack"}, 64'(o.a), 64'(a));
         chk({tag, "_adv"}, 64'(o.adv), 64'(adv));
         chk({tag, "_rt"}, 64'(o.rt), 64'(rt));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  f;
      logic [31:0] base;
      logic [31:0] a;
      clk = 1'b0; rst_n = 1'b0; n_checks = 0; n_errors = 0; prev_stall = 1'b0; held = 64'd0;
      bus.init_val = 1'b0; bus.init_flow_id = 4'd0; bus.init_ack_num = 32'd0;
      bus.ack_val = 1'b0; bus.ack_flow_id = 4'd0; bus.ack_num = 32'd0; bus.ack_snd_nxt = 32'd0;
      bus.upd_rdy = 1'b1;
      model_clear();
      #3;
      chk("rst_upd_val", 64'(bus.upd_val), 64'd0);
      chk("rst_upd_ack", 64'(bus.upd_ack_num), 64'd0);
      chk("rst_upd_flags", 64'({bus.upd_flow_id, bus.upd_tx_head_ptr, bus.upd_advanced, bus.upd_rt}), 64'd0);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_init_rdy", 64'(bus.init_rdy), 64'd1);
      chk("rst_ack_rdy", 64'(bus.ack_rdy), 64'd1);

      // Basic advance with two-cycle latency.
      send_init(4'd2, 32'd1000);
      send_ack(4'd2, 32'd1500, 32'd2000);
      chk("lat_n1_val", 64'(bus.upd_val), 64'd0);
      @(posedge clk); #1;
      chk("lat_n2_val", 64'(bus.upd_val), 64'd1);
      chk("lat_n2_ack", 64'(bus.upd_ack_num), 64'd1500);
      chk("lat_n2_ptr", 64'(bus.upd_tx_head_ptr), 64'd1500);
      chk("lat_n2_adv", 64'(bus.upd_advanced), 64'd1);
      chk("lat_n2_rt", 64'(bus.upd_rt), 64'd0);
      drain();
      expect_obs("basic", 4'd2, 32'd1500, 1'b1, 1'b0);

      // Fast retransmit on every third duplicate, back to back via bypass.
      for (int i = 0; i < 6; i++) send_ack(4'd2, 32'd1500, 32'd2000);
      drain();
      for (int i = 0; i < 6; i++) expect_obs("dup", 4'd2, 32'd1500, 1'b0, (i == 2 || i == 5));

      // Wrap-around window.
      send_init(4'd4, 32'hFFFF_FFF0);
      send_ack(4'd4, 32'h0000_0008, 32'h0000_0010);
      send_init(4'd4, 32'hFFFF_FFF0);
      send_ack(4'd4, 32'h0000_0008, 32'h0000_0004);
      send_ack(4'd4, 32'hFFFF_FFF0, 32'h0000_0010);
      send_ack(4'd4, 32'h0000_0020, 32'h0000_0010);
      for (int i = 0; i < 3; i++) send_ack(4'd4, 32'hFFFF_FFF0, 32'h0000_0010);
      drain();
      expect_obs("wrap_adv", 4'd4, 32'h0000_0008, 1'b1, 1'b0);
      expect_obs("wrap_rej", 4'd4, 32'hFFFF_FFF0, 1'b0, 1'b0);
      expect_obs("wrap_dup1", 4'd4, 32'hFFFF_FFF0, 1'b0, 1'b0);
      expect_obs("wrap_ood", 4'd4, 32'hFFFF_FFF0, 1'b0, 1'b0);
      expect_obs("wrap_clr1", 4'd4, 32'hFFFF_FFF0, 1'b0, 1'b0);
      expect_obs("wrap_clr2", 4'd4, 32'hFFFF_FFF0, 1'b0, 1'b0);
      expect_obs("wrap_clr3", 4'd4, 32'hFFFF_FFF0, 1'b0, 1'b1);

      // Back-to-back same flow.
      send_init(4'd5, 32'd100);
      for (int i = 0; i < 3; i++) send_ack(4'd5, 32'd100, 32'd300);
      send_ack(4'd5, 32'd200, 32'd300);
      drain();
      expect_obs("b2b_1", 4'd5, 32'd100, 1'b0, 1'b0);
      expect_obs("b2b_2", 4'd5, 32'd100, 1'b0, 1'b0);
      expect_obs("b2b_3", 4'd5, 32'd100, 1'b0, 1'b1);
      expect_obs("b2b_4", 4'd5, 32'd200, 1'b1, 1'b0);

      // Backpressure.
      send_init(4'd6, 32'd500);
      send_init(4'd7, 32'd600);
      bus.upd_rdy = 1'b0;
      send_ack(4'd6, 32'd550, 32'd700);
      send_ack(4'd7, 32'd650, 32'd700);
      bus.ack_val = 1'b1; bus.ack_flow_id = 4'd6; bus.ack_num = 32'd600; bus.ack_snd_nxt = 32'd700;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_ack_rdy", 64'(bus.ack_rdy), 64'd0);
         chk("bp_init_rdy", 64'(bus.init_rdy), 64'd0);
         chk("bp_upd_val", 64'(bus.upd_val), 64'd1);
         chk("bp_upd_ack", 64'(bus.upd_ack_num), 64'd550);
      end
      @(posedge clk); #1;
      bus.upd_rdy = 1'b1;
      send_ack(4'd6, 32'd600, 32'd700);
      drain();
      expect_obs("bp_a", 4'd6, 32'd550, 1'b1, 1'b0);
      expect_obs("bp_b", 4'd7, 32'd650, 1'b1, 1'b0);
      expect_obs("bp_c", 4'd6, 32'd600, 1'b1, 1'b0);
      chk("bp_no_extra", 64'(obs_q.size()), 64'd0);

      // Init collides with S1 writeback of the same flow.
      send_init(4'd3, 32'd3000);
      send_ack(4'd3, 32'd3100, 32'd3500);
      send_init(4'd3, 32'd9000);
      send_ack(4'd3, 32'd3100, 32'd9200);
      drain();
      expect_obs("coll_s1", 4'd3, 32'd3100, 1'b1, 1'b0);
      expect_obs("coll_next", 4'd3, 32'd9000, 1'b0, 1'b0);

      // Simultaneous init and ack: init first.
      bus.init_val = 1'b1; bus.init_flow_id = 4'd1; bus.init_ack_num = 32'd50;
      bus.ack_val = 1'b1; bus.ack_flow_id = 4'd1; bus.ack_num = 32'd50; bus.ack_snd_nxt = 32'd80;
      @(negedge clk);
      chk("simul_ack_rdy", 64'(bus.ack_rdy), 64'd0);
      chk("simul_init_rdy", 64'(bus.init_rdy), 64'd1);
      @(posedge clk); #1;
      bus.init_val = 1'b0;
      @(negedge clk);
      chk("simul_ack_rdy_after", 64'(bus.ack_rdy), 64'd1);
      @(posedge clk); #1;
      bus.ack_val = 1'b0;
      drain();
      expect_obs("simul", 4'd1, 32'd50, 1'b0, 1'b0);
      chk("simul_single", 64'(obs_q.size()), 64'd0);

      // Reset mid-operation.
      send_ack(4'd2, 32'd1600, 32'd2000);
      send_ack(4'd2, 32'd1700, 32'd2000);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_upd_val", 64'(bus.upd_val), 64'd0);
      chk("mid_rst_upd_ack", 64'(bus.upd_ack_num), 64'd0);
      exp_q.delete();
      obs_q.delete();
      model_clear();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("mid_rst_no_partial", 64'(obs_q.size()), 64'd0);
      send_ack(4'd2, 32'd5, 32'd10);
      drain();
      expect_obs("post_rst", 4'd2, 32'd5, 1'b1, 1'b0);

      // Random traffic on a few flows to exercise bypass, init collisions and stalls.
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         bus.upd_rdy = ($urandom_range(0, 3) != 0);
         bus.init_val = ($urandom_range(0, 9) == 0);
         bus.init_flow_id = 4'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) bus.init_ack_num = 32'hFFFF_FFE0 + 32'($urandom_range(0, 15));
         else bus.init_ack_num = $urandom;
         bus.ack_val = ($urandom_range(0, 9) < 7);
         f = 4'($urandom_range(0, 3));
         base = m_ack[f];
         case ($urandom_range(0, 3))
            0: a = base;
            1: a = base + 32'($urandom_range(1, 40));
            2: a = base - 32'($urandom_range(1, 40));
            default: a = $urandom;
         endcase
         bus.ack_flow_id = f;
         bus.ack_num = a;
         bus.ack_snd_nxt = base + 32'($urandom_range(0, 48));
      end
      @(posedge clk); #1;
      bus.init_val = 1'b0;
      bus.ack_val = 1'b0;
      drain();
      obs_q.delete();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
